piso_serializer: RTL and testbench

//   Parallel-in/serial-out stage directly downstream of the 4-bit D-register bank.

---
 rtl/piso_serializer_if.sv | 56 +++++
 rtl/piso_serializer.sv | 189 ++++++++++++++++++
 tb/tb_piso_serializer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// ---------------------------------------------------------------------------
// piso_serializer_if
//   Bundles the upstream word handshake and the serial-side outputs of the
//   nibble serializer so both travel as one port.
//
//   Signals
//     valid          upstream nibble d3..d0 is valid this cycle
//     d3..d0         parallel nibble, d3 is the MSB
//     ready          serializer accepts a word this cycle
//     sout           serial data bit
//     frame          high on every cycle sout carries a data bit
//     last           high with the final (4th) bit of a word
//     wordcnt[3:0]   completed-word count, wraps 15 -> 0
//
//   Modports
//     slave   the serializer itself (consumes the word, drives serial side)
//     master  the upstream register bank / link observer
// ---------------------------------------------------------------------------
interface piso_serializer_if;
    logic       valid;
    logic       d3;
    logic       d2;
    logic       d1;
    logic       d0;
    logic       ready;
    logic       sout;
    logic       frame;
    logic       last;
    logic [3:0] wordcnt;

    modport slave (
        input  valid,
        input  d3,
        input  d2,
        input  d1,
        input  d0,
        output ready,
        output sout,
        output frame,
        output last,
        output wordcnt
    );

    modport master (
        output valid,
        output d3,
        output d2,
        output d1,
        output d0,
        input  ready,
        input  sout,
        input  frame,
        input  last,
        input  wordcnt
    );
endinterface

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out stage fed by the 4-bit register bank. A nibble
//   is taken under a valid/ready handshake and shifted out one bit per clock
//   with frame/last strobes. A wrapping counter tracks completed words.
//
//   Parameters
//     MSB_FIRST  1: bit order d3,d2,d1,d0   0: d0,d1,d2,d3
//     GAP        idle cycles forced after each word (0..15); 0 permits
//                back-to-back words with no idle cycle between them
//
//   Ports
//     clock      single clock, everything updates on the rising edge
//     clear      synchronous active-low reset
//     bus        piso_serializer_if.slave (handshake + serial outputs)
//
//   Timing
//     A word accepted at edge k shows bit 0 on sout right after edge k;
//     bits 1..3 follow on the next three cycles. sout/frame/last/wordcnt
//     are registered; ready is decoded from the state registers only.
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic              clock,
    input  logic              clear,
    piso_serializer_if.slave  bus
);

    // GAP is only meaningful in 0..15; the 4-bit gap counter is loaded with
    // GAP-1 when a word ends so that exactly GAP idle cycles elapse.
    localparam bit         GAP_NONE = (GAP == 0);
    localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAPW  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t     state_reg,   state_next;
    logic [3:0] word_reg,    word_next;
    logic [1:0] bitcnt_reg,  bitcnt_next;
    logic [3:0] gapcnt_reg,  gapcnt_next;
    logic [3:0] wordcnt_reg, wordcnt_next;
    logic       sout_reg,    sout_next;
    logic       frame_reg,   frame_next;
    logic       last_reg,    last_next;

    logic       ready;
    logic       accept;
    logic [3:0] word_in;

    // Bits of the word that will be held after this edge, already arranged
    // in transmit order: ordered_bits[n] is the n-th bit to go out.
    logic [3:0] ordered_bits;

    assign word_in = {bus.d3, bus.d2, bus.d1, bus.d0};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_order
            if (MSB_FIRST) begin : g_msb
                assign ordered_bits[gi] = word_next[3 - gi];
            end else begin : g_lsb
                assign ordered_bits[gi] = word_next[gi];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake: ready depends on state only. With GAP==0 the final bit
    // cycle also accepts, which is what makes back-to-back words seamless.
    // ------------------------------------------------------------------
    always_comb begin
        ready = 1'b0;
        case (state_reg)
            IDLE:    ready = 1'b1;
            SHIFT:   ready = GAP_NONE && (bitcnt_reg == 2'd3);
            default: ready = 1'b0;
        endcase
    end

    assign accept = bus.valid && ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        word_next    = word_reg;
        bitcnt_next  = bitcnt_reg;
        gapcnt_next  = gapcnt_reg;
        wordcnt_next = wordcnt_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next  = SHIFT;
                    word_next   = word_in;
                    bitcnt_next = 2'd0;
                end
            end

            SHIFT: begin
                if (bitcnt_reg != 2'd3) begin
                    bitcnt_next = bitcnt_reg + 2'd1;
                end else begin
                    // Leaving the final bit: the word is complete.
                    wordcnt_next = wordcnt_reg + 4'd1;
                    if (accept) begin
                        state_next  = SHIFT;
                        word_next   = word_in;
                        bitcnt_next = 2'd0;
                    end else if (GAP_NONE) begin
                        state_next  = IDLE;
                    end else begin
                        state_next  = GAPW;
                        gapcnt_next = GAP_LOAD;
                    end
                end
            end

            GAPW: begin
                if (gapcnt_reg == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    gapcnt_next = gapcnt_reg - 4'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered serial outputs are derived from the state being entered,
    // so bit 0 appears on sout in the cycle right after the accept edge.
    // ------------------------------------------------------------------
    always_comb begin
        sout_next  = 1'b0;
        frame_next = 1'b0;
        last_next  = 1'b0;
        if (state_next == SHIFT) begin
            sout_next  = ordered_bits[bitcnt_next];
            frame_next = 1'b1;
            last_next  = (bitcnt_next == 2'd3);
        end
    end

    // ------------------------------------------------------------------
    // State register; clear wins over every other activity, including a
    // word in flight, and the partial word is simply dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_reg   <= IDLE;
            word_reg    <= 4'd0;
            bitcnt_reg  <= 2'd0;
            gapcnt_reg  <= 4'd0;
            wordcnt_reg <= 4'd0;
            sout_reg    <= 1'b0;
            frame_reg   <= 1'b0;
            last_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            word_reg    <= word_next;
            bitcnt_reg  <= bitcnt_next;
            gapcnt_reg  <= gapcnt_next;
            wordcnt_reg <= wordcnt_next;
            sout_reg    <= sout_next;
            frame_reg   <= frame_next;
            last_reg    <= last_next;
        end
    end

    assign bus.ready   = ready;
    assign bus.sout    = sout_reg;
    assign bus.frame   = frame_reg;
    assign bus.last    = last_reg;
    assign bus.wordcnt = wordcnt_reg;

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//   Directed bench for piso_serializer. Three instances share clock and
//   clear: m (MSB first, no gap), l (LSB first, no gap), g (MSB first,
//   GAP=3). Inputs are driven and outputs sampled 1 time unit after the
//   rising edge.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

    logic clock;
    logic clear;

    int compared;
    int mismatched;

    piso_serializer_if m_if ();
    piso_serializer_if l_if ();
    piso_serializer_if g_if ();

    piso_serializer #(.MSB_FIRST(1'b1), .GAP(0)) u_m (
        .clock (clock),
        .clear (clear),
        .bus   (m_if)
    );

    piso_serializer #(.MSB_FIRST(1'b0), .GAP(0)) u_l (
        .clock (clock),
        .clear (clear),
        .bus   (l_if)
    );

    piso_serializer #(.MSB_FIRST(1'b1), .GAP(3)) u_g (
        .clock (clock),
        .clear (clear),
        .bus   (g_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_m(input logic v, input logic [3:0] nib);
        m_if.valid = v;
        {m_if.d3, m_if.d2, m_if.d1, m_if.d0} = nib;
    endtask

    task automatic drive_l(input logic v, input logic [3:0] nib);
        l_if.valid = v;
        {l_if.d3, l_if.d2, l_if.d1, l_if.d0} = nib;
    endtask

    task automatic drive_g(input logic v, input logic [3:0] nib);
        g_if.valid = v;
        {g_if.d3, g_if.d2, g_if.d1, g_if.d0} = nib;
    endtask

    logic [7:0] lsb_bits;
    logic [3:0] msb_word;

    initial begin
        compared   = 0;
        mismatched = 0;
        clear      = 1'b0;
        drive_m(1'b0, 4'h0);
        drive_l(1'b0, 4'h0);
        drive_g(1'b0, 4'h0);

        // ---- 1: reset held for two edges, then released ----
        tick();
        tick();
        chk("rst_sout",    {3'd0, m_if.sout},  4'd0);
        chk("rst_frame",   {3'd0, m_if.frame}, 4'd0);
        chk("rst_last",    {3'd0, m_if.last},  4'd0);
        chk("rst_wordcnt", m_if.wordcnt,       4'd0);
        chk("rst_ready",   {3'd0, m_if.ready}, 4'd1);
        chk("rst_ready_g", {3'd0, g_if.ready}, 4'd1);
        clear = 1'b1;
        tick();
        chk("idle_frame",  {3'd0, m_if.frame}, 4'd0);
        chk("idle_ready",  {3'd0, l_if.ready}, 4'd1);

        // ---- 5: clear mid-word at bitcnt==2 of 0110 ----
        drive_m(1'b1, 4'b0110);
        tick();
        drive_m(1'b0, 4'h0);
        chk("mid_b0_sout",  {3'd0, m_if.sout},  4'd0);
        chk("mid_b0_ready", {3'd0, m_if.ready}, 4'd0);
        tick();
        chk("mid_b1_sout",  {3'd0, m_if.sout},  4'd1);
        tick();
        chk("mid_b2_sout",  {3'd0, m_if.sout},  4'd1);
        chk("mid_b2_frame", {3'd0, m_if.frame}, 4'd1);
        clear = 1'b0;
        tick();
        clear = 1'b1;
        chk("mid_clr_frame",   {3'd0, m_if.frame}, 4'd0);
        chk("mid_clr_sout",    {3'd0, m_if.sout},  4'd0);
        chk("mid_clr_ready",   {3'd0, m_if.ready}, 4'd1);
        chk("mid_clr_wordcnt", m_if.wordcnt,       4'd0);
        tick();
        chk("mid_after_frame", {3'd0, m_if.frame}, 4'd0);

        // ---- 2: MSB first, single pulse of 1011 -> 1,0,1,1 ----
        msb_word = 4'b1011;
        drive_m(1'b1, msb_word);
        tick();
        drive_m(1'b0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            chk($sformatf("msb_sout%0d", i),  {3'd0, m_if.sout},  {3'd0, msb_word[3 - i]});
            chk($sformatf("msb_frame%0d", i), {3'd0, m_if.frame}, 4'd1);
            chk($sformatf("msb_last%0d", i),  {3'd0, m_if.last},  (i == 3) ? 4'd1 : 4'd0);
            chk($sformatf("msb_ready%0d", i), {3'd0, m_if.ready}, (i == 3) ? 4'd1 : 4'd0);
            chk($sformatf("msb_wc%0d", i),    m_if.wordcnt,       4'd0);
        end
        tick();
        chk("msb_end_frame", {3'd0, m_if.frame}, 4'd0);
        chk("msb_end_sout",  {3'd0, m_if.sout},  4'd0);
        chk("msb_end_wc",    m_if.wordcnt,       4'd1);

        // ---- 3: LSB first, back-to-back 1100 then 0011 ----
        lsb_bits = 8'b0011_1100;  // transmit order, bit 0 first: 0,0,1,1,1,1,0,0
        drive_l(1'b1, 4'b1100);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 3) drive_l(1'b1, 4'b0011);
            if (i == 4) drive_l(1'b0, 4'h0);
            chk($sformatf("lsb_sout%0d", i),  {3'd0, l_if.sout},  {3'd0, lsb_bits[i]});
            chk($sformatf("lsb_frame%0d", i), {3'd0, l_if.frame}, 4'd1);
            chk($sformatf("lsb_last%0d", i),  {3'd0, l_if.last},
                (i == 3 || i == 7) ? 4'd1 : 4'd0);
            if (i == 4) chk("lsb_wc_mid", l_if.wordcnt, 4'd1);
        end
        tick();
        chk("lsb_end_frame", {3'd0, l_if.frame}, 4'd0);
        chk("lsb_end_wc",    l_if.wordcnt,       4'd2);

        // ---- 4: GAP=3, valid held with 1111 ----
        drive_g(1'b1, 4'b1111);
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c <= 4) begin
                chk($sformatf("gap_data_sout%0d", c),  {3'd0, g_if.sout},  4'd1);
                chk($sformatf("gap_data_frame%0d", c), {3'd0, g_if.frame}, 4'd1);
                chk($sformatf("gap_data_ready%0d", c), {3'd0, g_if.ready}, 4'd0);
            end else if (c <= 7) begin
                chk($sformatf("gap_idle_sout%0d", c),  {3'd0, g_if.sout},  4'd0);
                chk($sformatf("gap_idle_frame%0d", c), {3'd0, g_if.frame}, 4'd0);
                chk($sformatf("gap_idle_ready%0d", c), {3'd0, g_if.ready}, 4'd0);
            end else if (c == 8) begin
                chk("gap_reopen_ready", {3'd0, g_if.ready}, 4'd1);
                chk("gap_reopen_frame", {3'd0, g_if.frame}, 4'd0);
                chk("gap_reopen_wc",    g_if.wordcnt,       4'd1);
            end else begin
                drive_g(1'b0, 4'h0);
                chk("gap_next_frame", {3'd0, g_if.frame}, 4'd1);
                chk("gap_next_sout",  {3'd0, g_if.sout},  4'd1);
            end
        end
        for (int c = 0; c < 8; c++) tick();
        chk("gap_final_wc",    g_if.wordcnt,       4'd2);
        chk("gap_final_ready", {3'd0, g_if.ready}, 4'd1);

        // ---- 6: valid during bitcnt 0..2 is ignored ----
        drive_m(1'b1, 4'b1111);
        tick();
        drive_m(1'b1, 4'b0000);
        tick();
        chk("ign_b1_sout", {3'd0, m_if.sout}, 4'd1);
        tick();
        drive_m(1'b0, 4'h0);
        chk("ign_b2_sout", {3'd0, m_if.sout}, 4'd1);
        tick();
        chk("ign_b3_sout", {3'd0, m_if.sout}, 4'd1);
        chk("ign_b3_last", {3'd0, m_if.last}, 4'd1);
        tick();
        chk("ign_end_frame", {3'd0, m_if.frame}, 4'd0);
        chk("ign_end_wc",    m_if.wordcnt,       4'd2);

        // ---- 6: fourteen more back-to-back words wrap wordcnt to 0 ----
        drive_m(1'b1, 4'b1010);
        for (int i = 1; i <= 57; i++) begin
            tick();
            if (i == 53) drive_m(1'b0, 4'h0);
            if (i == 56) chk("wrap_wc15", m_if.wordcnt, 4'd15);
            if (i == 29) chk("wrap_frame_mid", {3'd0, m_if.frame}, 4'd1);
        end
        chk("wrap_wc0",    m_if.wordcnt,       4'd0);
        chk("wrap_frame0", {3'd0, m_if.frame}, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
